hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage MIPS core; it consumes the outputs of the ID/EX register and drives that register's clear input.
- Generates F/D/E/M stall enables, the D and E flushes, and the EX- and ID-stage forwarding selects.
- Contains a sequential memory-wait FSM with timeout for a data memory that may take multiple cycles to acknowledge.

---
 rtl/hazard_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard unit for the 5-stage MIPS pipeline.
// Produces stage stalls/flushes, EX and ID forwarding selects, and runs a
// memory-wait FSM that times out into a sticky error state.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating stall counters.
module hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 5
) (
   input  logic       clk,
   input  logic       clr,
   input  logic [4:0] RsD,
   input  logic [4:0] RtD,
   input  logic       BranchD,
   input  logic       PCSrcD,
   input  logic [4:0] RsE,
   input  logic [4:0] RtE,
   input  logic [4:0] WriteRegE,
   input  logic       RegWriteE,
   input  logic       MemtoRegE,
   input  logic [4:0] WriteRegM,
   input  logic       RegWriteM,
   input  logic       MemtoRegM,
   input  logic       MemReqM,
   input  logic       MemReadyM,
   input  logic [4:0] WriteRegW,
   input  logic       RegWriteW,
   output logic       StallF,
   output logic       StallD,
   output logic       StallE,
   output logic       StallM,
   output logic       FlushD,
   output logic       FlushE,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       ForwardAD,
   output logic       ForwardBD,
   output logic       MemErr
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] LwStallCnt,
   output logic [31:0] BrStallCnt,
   output logic [31:0] MemStallCnt
`endif
);

   localparam logic [1:0] S_RUN      = 2'd0;
   localparam logic [1:0] S_WAIT_MEM = 2'd1;
   localparam logic [1:0] S_ERR      = 2'd2;

   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   logic [1:0]       state;
   logic [CNT_W-1:0] wait_cnt;
   logic             mem_err;
   logic             lwstall;
   logic             brstall;
   logic             memstall;

   // Register $0 is hardwired to zero, so it never participates in a match.
   function automatic logic [1:0] ex_fwd(input logic [4:0] src,
                                         input logic       wr_m,
                                         input logic [4:0] dst_m,
                                         input logic       wr_w,
                                         input logic [4:0] dst_w);
      if (src == '0)
         return 2'b00;
      else if (wr_m && dst_m == src)
         return 2'b10;
      else if (wr_w && dst_w == src)
         return 2'b01;
      else
         return 2'b00;
   endfunction

   function automatic logic hits_id(input logic [4:0] dst,
                                    input logic [4:0] rs,
                                    input logic [4:0] rt);
      return (dst != '0) && (dst == rs || dst == rt);
   endfunction

   // Hazard detection: load-use, branch operand not yet ready, memory wait.
   always_comb begin
      lwstall  = MemtoRegE && hits_id(WriteRegE, RsD, RtD);
      brstall  = BranchD && ((RegWriteE && hits_id(WriteRegE, RsD, RtD)) ||
                             (MemtoRegM && hits_id(WriteRegM, RsD, RtD)));
      memstall = (state == S_RUN && MemReqM && !MemReadyM) ||
                 (state == S_WAIT_MEM && !MemReadyM) ||
                 (state == S_ERR);
   end

   // Output decode: reset forces flushes, memory stall freezes everything.
   always_comb begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      ForwardAD = 1'b0;
      ForwardBD = 1'b0;
      if (clr) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
      end else begin
         ForwardAE = ex_fwd(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
         ForwardBE = ex_fwd(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
         ForwardAD = (RsD != '0) && RegWriteM && (WriteRegM == RsD);
         ForwardBD = (RtD != '0) && RegWriteM && (WriteRegM == RtD);
         if (memstall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
         end else begin
            StallF = lwstall | brstall;
            StallD = lwstall | brstall;
            FlushE = lwstall | brstall;
            FlushD = PCSrcD && !(lwstall | brstall);
         end
      end
   end

   // Memory-wait FSM; counter holds the number of stalled cycles so far.
   always_ff @(posedge clk) begin
      if (clr) begin
         state    <= S_RUN;
         wait_cnt <= '0;
         mem_err  <= 1'b0;
      end else begin
         case (state)
            S_RUN: begin
               if (MemReqM && !MemReadyM) begin
                  state    <= S_WAIT_MEM;
                  wait_cnt <= CNT_W'(1);
               end
            end
            S_WAIT_MEM: begin
               if (MemReadyM) begin
                  state    <= S_RUN;
                  wait_cnt <= '0;
               end else if (wait_cnt == WAIT_LAST) begin
                  state   <= S_ERR;
                  mem_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            S_ERR: begin
               mem_err <= 1'b1;
            end
            default: begin
               state    <= S_RUN;
               wait_cnt <= '0;
            end
         endcase
      end
   end

   assign MemErr = mem_err;

`ifdef HAZARD_PERF_CNT_EN
   // Saturating counters of cycles actually lost to each stall cause.
   always_ff @(posedge clk) begin
      if (clr) begin
         LwStallCnt  <= '0;
         BrStallCnt  <= '0;
         MemStallCnt <= '0;
      end else begin
         if (lwstall && !memstall && LwStallCnt != '1)
            LwStallCnt <= LwStallCnt + 32'd1;
         if (brstall && !memstall && BrStallCnt != '1)
            BrStallCnt <= BrStallCnt + 32'd1;
         if (memstall && MemStallCnt != '1)
            MemStallCnt <= MemStallCnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model.
module tb_hazard_ctrl;
   localparam int unsigned TO = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       clr = 1'b1;
   logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
   logic       BranchD, PCSrcD, RegWriteE, MemtoRegE, RegWriteM, MemtoRegM;
   logic       MemReqM, MemReadyM, RegWriteW;
   logic       StallF, StallD, StallE, StallM, FlushD, FlushE;
   logic [1:0] ForwardAE, ForwardBE;
   logic       ForwardAD, ForwardBD, MemErr;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] LwStallCnt, BrStallCnt, MemStallCnt;
`endif

   hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(5)) dut (
      .clk(clk), .clr(clr), .RsD(RsD), .RtD(RtD), .BranchD(BranchD),
      .PCSrcD(PCSrcD), .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE),
      .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .WriteRegM(WriteRegM),
      .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemReqM(MemReqM),
      .MemReadyM(MemReadyM), .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE),
      .ForwardBE(ForwardBE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
      .MemErr(MemErr)
`ifdef HAZARD_PERF_CNT_EN
      , .LwStallCnt(LwStallCnt), .BrStallCnt(BrStallCnt), .MemStallCnt(MemStallCnt)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Behavioural model state: outstanding memory wait, cycles waited, error.
   bit      m_busy   = 1'b0;
   int      m_waited = 0;
   bit      m_err    = 1'b0;
   longint  m_lw = 0, m_br = 0, m_mem = 0;

   typedef struct packed {
      logic sf, sd, se, sm, fd, fe;
      logic [1:0] fae, fbe;
      logic fad, fbd, err;
   } exp_t;

   function automatic logic [1:0] m_fwd(input logic [4:0] r);
      if (r == 0) return 2'd0;
      if (RegWriteM && WriteRegM == r) return 2'd2;
      if (RegWriteW && WriteRegW == r) return 2'd1;
      return 2'd0;
   endfunction

   function automatic bit m_uses(input logic [4:0] w);
      return (w != 0) && (w == RsD || w == RtD);
   endfunction

   function automatic bit m_lwstall();
      return MemtoRegE && m_uses(WriteRegE);
   endfunction

   function automatic bit m_brstall();
      return BranchD && ((RegWriteE && m_uses(WriteRegE)) || (MemtoRegM && m_uses(WriteRegM)));
   endfunction

   function automatic bit m_memstall();
      return m_err || (!MemReadyM && (m_busy || MemReqM));
   endfunction

   function automatic exp_t model_eval();
      exp_t e;
      bit h;
      e = '0;
      e.err = m_err;
      if (clr) begin
         e.fd = 1'b1;
         e.fe = 1'b1;
         return e;
      end
      e.fae = m_fwd(RsE);
      e.fbe = m_fwd(RtE);
      e.fad = (RsD != 0) && RegWriteM && WriteRegM == RsD;
      e.fbd = (RtD != 0) && RegWriteM && WriteRegM == RtD;
      h = m_lwstall() || m_brstall();
      if (m_memstall()) begin
         {e.sf, e.sd, e.se, e.sm} = 4'hF;
      end else begin
         e.sf = h;
         e.sd = h;
         e.fe = h;
         e.fd = PCSrcD && !h;
      end
      return e;
   endfunction

   // Model advance at each rising edge.
   always @(posedge clk) begin
      if (clr) begin
         m_busy <= 1'b0; m_waited <= 0; m_err <= 1'b0;
         m_lw <= 0; m_br <= 0; m_mem <= 0;
      end else begin
         if (!m_memstall() && m_lwstall() && m_lw < 64'hFFFFFFFF) m_lw <= m_lw + 1;
         if (!m_memstall() && m_brstall() && m_br < 64'hFFFFFFFF) m_br <= m_br + 1;
         if (m_memstall() && m_mem < 64'hFFFFFFFF) m_mem <= m_mem + 1;
         if (!m_err) begin
            if (m_memstall()) begin
               m_waited <= m_waited + 1;
               if (m_waited + 1 >= TO) begin
                  m_err  <= 1'b1;
                  m_busy <= 1'b0;
               end else begin
                  m_busy <= 1'b1;
               end
            end else begin
               m_busy   <= 1'b0;
               m_waited <= 0;
            end
         end
      end
   end

   task automatic idle();
      RsD = 0; RtD = 0; RsE = 0; RtE = 0; WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
      BranchD = 0; PCSrcD = 0; RegWriteE = 0; MemtoRegE = 0; RegWriteM = 0;
      MemtoRegM = 0; MemReqM = 0; MemReadyM = 1; RegWriteW = 0;
   endtask

   task automatic do_reset();
      @(negedge clk); idle(); clr = 1'b1;
      @(negedge clk); clr = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk); idle(); clr = 1'b1;
      RegWriteM = 1; WriteRegM = 2; RsE = 2; RsD = 2; MemReqM = 1; MemReadyM = 0;
      PCSrcD = 1;
      @(negedge clk); #1;
      checks++;
      if ({StallF, StallD, StallE, StallM} !== 4'h0) begin errors++;
         $display("FAIL reset_stalls: got %b expected 0000", {StallF, StallD, StallE, StallM}); end
      checks++;
      if ({FlushD, FlushE} !== 2'b11) begin errors++;
         $display("FAIL reset_flush: got %b expected 11", {FlushD, FlushE}); end
      checks++;
      if ({ForwardAE, ForwardBE, ForwardAD, ForwardBD} !== 6'h0) begin errors++;
         $display("FAIL reset_fwd: got %b expected 000000", {ForwardAE, ForwardBE, ForwardAD, ForwardBD}); end
      checks++;
      if (MemErr !== 1'b0) begin errors++;
         $display("FAIL reset_memerr: got %b expected 0", MemErr); end
      @(negedge clk); clr = 1'b0; #1;
      checks++;
      if (StallM !== 1'b1 || ForwardAE !== 2'b10) begin errors++;
         $display("FAIL post_reset: got StallM=%b AE=%b expected 1/10", StallM, ForwardAE); end
      do_reset();
   endtask

   task automatic test_load_use();
      do_reset();
      @(negedge clk); idle(); MemtoRegE = 1; RegWriteE = 1; WriteRegE = 2; RsD = 2; RtD = 4; #1;
      checks++;
      if ({StallF, StallD, StallE, StallM, FlushD, FlushE} !== 6'b110001) begin errors++;
         $display("FAIL lw_bubble: got %b expected 110001", {StallF, StallD, StallE, StallM, FlushD, FlushE}); end
      @(negedge clk); idle(); MemtoRegM = 1; RegWriteM = 1; WriteRegM = 2; MemReqM = 1;
      MemReadyM = 1; RsD = 2; RtD = 4; #1;
      checks++;
      if ({StallF, StallD, StallM, FlushE} !== 4'b0000) begin errors++;
         $display("FAIL lw_released: got %b expected 0000", {StallF, StallD, StallM, FlushE}); end
      @(negedge clk); idle(); RegWriteW = 1; WriteRegW = 2; RsE = 2; RtE = 4; #1;
      checks++;
      if (ForwardAE !== 2'b01 || ForwardBE !== 2'b00) begin errors++;
         $display("FAIL lw_fwd_wb: got AE=%b BE=%b expected 01/00", ForwardAE, ForwardBE); end
   endtask

   task automatic test_forwarding();
      @(negedge clk); idle(); RegWriteM = 1; WriteRegM = 2; RegWriteW = 1; WriteRegW = 2;
      RsE = 2; RtE = 2; #1;
      checks++;
      if (ForwardAE !== 2'b10 || ForwardBE !== 2'b10) begin errors++;
         $display("FAIL fwd_mem_prio: got AE=%b BE=%b expected 10/10", ForwardAE, ForwardBE); end
      @(negedge clk); idle(); RegWriteM = 1; RegWriteW = 1; #1;
      checks++;
      if (ForwardAE !== 2'b00 || ForwardBE !== 2'b00) begin errors++;
         $display("FAIL fwd_r0: got AE=%b BE=%b expected 00/00", ForwardAE, ForwardBE); end
      @(negedge clk); idle(); RegWriteW = 1; WriteRegW = 7; RtE = 7; RsE = 3; #1;
      checks++;
      if (ForwardAE !== 2'b00 || ForwardBE !== 2'b01) begin errors++;
         $display("FAIL fwd_wb: got AE=%b BE=%b expected 00/01", ForwardAE, ForwardBE); end
   endtask

   task automatic test_branch();
      @(negedge clk); idle(); BranchD = 1; RsD = 2; RtD = 3; RegWriteE = 1; WriteRegE = 2;
      PCSrcD = 1; #1;
      checks++;
      if ({StallF, StallD, FlushD, FlushE} !== 4'b1101) begin errors++;
         $display("FAIL br_stall: got %b expected 1101", {StallF, StallD, FlushD, FlushE}); end
      @(negedge clk); idle(); BranchD = 1; RsD = 2; RtD = 3; RegWriteM = 1; WriteRegM = 2;
      PCSrcD = 1; #1;
      checks++;
      if ({ForwardAD, ForwardBD, StallF, FlushE, FlushD} !== 5'b10001) begin errors++;
         $display("FAIL br_fwd_taken: got %b expected 10001", {ForwardAD, ForwardBD, StallF, FlushE, FlushD}); end
      @(negedge clk); idle(); BranchD = 1; RsD = 2; RtD = 3; RegWriteM = 1; MemtoRegM = 1;
      WriteRegM = 3; #1;
      checks++;
      if ({StallD, FlushE, ForwardBD} !== 3'b111) begin errors++;
         $display("FAIL br_load_mem: got %b expected 111", {StallD, FlushE, ForwardBD}); end
   endtask

   task automatic test_mem_wait();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); idle(); MemReqM = 1; MemReadyM = 0; #1;
         checks++;
         if ({StallF, StallD, StallE, StallM, FlushD, FlushE} !== 6'b111100) begin errors++;
            $display("FAIL mem_wait_%0d: got %b expected 111100", i, {StallF, StallD, StallE, StallM, FlushD, FlushE}); end
      end
      @(negedge clk); idle(); MemReqM = 1; MemReadyM = 1; #1;
      checks++;
      if ({StallF, StallD, StallE, StallM} !== 4'h0) begin errors++;
         $display("FAIL mem_ack: got %b expected 0000", {StallF, StallD, StallE, StallM}); end
      @(negedge clk); idle(); MemReadyM = 0; #1;
      checks++;
      if ({StallF, StallM} !== 2'b00) begin errors++;
         $display("FAIL mem_back_run: got %b expected 00", {StallF, StallM}); end
   endtask

   task automatic test_priority();
      do_reset();
      @(negedge clk); idle(); MemtoRegE = 1; WriteRegE = 2; RsD = 2; PCSrcD = 1;
      MemReqM = 1; MemReadyM = 0; #1;
      checks++;
      if ({StallF, StallD, StallE, StallM, FlushD, FlushE} !== 6'b111100) begin errors++;
         $display("FAIL prio_mem_wins: got %b expected 111100", {StallF, StallD, StallE, StallM, FlushD, FlushE}); end
      @(negedge clk); MemReadyM = 1; #1;
      checks++;
      if ({StallF, StallD, StallE, StallM, FlushD, FlushE} !== 6'b110001) begin errors++;
         $display("FAIL prio_bubble_after: got %b expected 110001", {StallF, StallD, StallE, StallM, FlushD, FlushE}); end
   endtask

   task automatic test_timeout();
      do_reset();
      for (int i = 0; i < int'(TO); i++) begin
         @(negedge clk); idle(); MemReqM = 1; MemReadyM = 0; #1;
         checks++;
         if (StallM !== 1'b1 || MemErr !== 1'b0) begin errors++;
            $display("FAIL timeout_wait_%0d: got StallM=%b MemErr=%b expected 1/0", i, StallM, MemErr); end
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); idle(); #1;
         checks++;
         if (MemErr !== 1'b1 || {StallF, StallD, StallE, StallM, FlushE} !== 5'b11110) begin errors++;
            $display("FAIL timeout_err_%0d: got MemErr=%b st=%b expected 1/11110", i, MemErr, {StallF, StallD, StallE, StallM, FlushE}); end
      end
      @(negedge clk); idle(); clr = 1'b1; #1;
      checks++;
      if ({StallF, StallD, StallE, StallM, FlushD, FlushE} !== 6'b000011) begin errors++;
         $display("FAIL timeout_clr: got %b expected 000011", {StallF, StallD, StallE, StallM, FlushD, FlushE}); end
      @(negedge clk); clr = 1'b0; #1;
      checks++;
      if (MemErr !== 1'b0 || {StallF, StallD, StallE, StallM} !== 4'h0) begin errors++;
         $display("FAIL timeout_cleared: got MemErr=%b st=%b expected 0/0000", MemErr, {StallF, StallD, StallE, StallM}); end
   endtask

   task automatic test_random();
      exp_t e;
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         clr = ($urandom_range(0, 99) < 2);
         RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
         RsE = 5'($urandom_range(0, 3)); RtE = 5'($urandom_range(0, 3));
         WriteRegE = 5'($urandom_range(0, 3)); WriteRegM = 5'($urandom_range(0, 3));
         WriteRegW = 5'($urandom_range(0, 3));
         BranchD = 1'($urandom); PCSrcD = 1'($urandom); RegWriteE = 1'($urandom);
         MemtoRegE = 1'($urandom); RegWriteM = 1'($urandom); MemtoRegM = 1'($urandom);
         RegWriteW = 1'($urandom); MemReqM = 1'($urandom);
         MemReadyM = ($urandom_range(0, 99) < 60);
         #1;
         e = model_eval();
         checks++;
         if ({StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE,
              ForwardAD, ForwardBD, MemErr} !== e) begin errors++;
            $display("FAIL random_%0d: got %b expected %b", n, {StallF, StallD, StallE, StallM,
               FlushD, FlushE, ForwardAE, ForwardBE, ForwardAD, ForwardBD, MemErr}, e); end
`ifdef HAZARD_PERF_CNT_EN
         checks++;
         if ({LwStallCnt, BrStallCnt, MemStallCnt} !== {32'(m_lw), 32'(m_br), 32'(m_mem)}) begin errors++;
            $display("FAIL perf_cnt_%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", n, LwStallCnt,
               BrStallCnt, MemStallCnt, m_lw, m_br, m_mem); end
`endif
      end
      clr = 1'b0;
   endtask

   initial begin
      idle();
      repeat (2) @(posedge clk);
      test_reset();
      test_load_use();
      test_forwarding();
      test_branch();
      test_mem_wait();
      test_priority();
      test_timeout();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
